bcd_counter: RTL and testbench

- Multi-digit synchronous BCD up/down counter with a built-in rate prescaler and a parallel load.
- Produces the packed BCD digit bus that feeds the bcd-to-7-segment decoder stage, one 4-bit nibble per digit.
- Gives the display path a legal 0–9 digit source, with carry/borrow ripple, terminal wrap flag and load validation.

---
 rtl/bcd_counter_if.sv | 25 ++
 rtl/bcd_counter.sv | 105 ++++++++++
 tb/tb_bcd_counter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_counter_if.sv
// Control and digit-bus bundle between the BCD counter and its controller.
// The counter consumes the slave view; whoever drives the strobes and reads
// the packed digits uses the master view.
interface bcd_counter_if #(
  parameter int NDIG = 4
);
  logic              en;
  logic              up;
  logic              load;
  logic [4*NDIG-1:0] load_val;
  logic [4*NDIG-1:0] bcd;
  logic              tick;
  logic              wrap;
  logic              load_err;

  modport master (
    output en, up, load, load_val,
    input  bcd, tick, wrap, load_err
  );

  modport slave (
    input  en, up, load, load_val,
    output bcd, tick, wrap, load_err
  );
endinterface

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with a rate prescaler and validated
// parallel load. Digit 0 lives in bcd[3:0]. All outputs are registered, and
// every nibble of bcd stays in 0..9 because only legal values are ever loaded
// and the step logic only produces legal digits.
// The interface instance must be built with the same NDIG as this module.
module bcd_counter #(
  parameter int NDIG       = 4,
  parameter int PRESCALE   = 4,
  parameter int PRESCALE_W = 16
) (
  input logic       clk,
  input logic       rst,
  bcd_counter_if.slave bus
);

  localparam logic [PRESCALE_W-1:0] PC_LAST = PRESCALE_W'(PRESCALE - 1);

  logic [PRESCALE_W-1:0] pc_q;
  logic [4*NDIG-1:0]     bcd_q;
  logic                  tick_q;
  logic                  wrap_q;
  logic                  load_err_q;

  logic [4*NDIG-1:0]     inc_val;
  logic [4*NDIG-1:0]     dec_val;
  logic                  inc_c;
  logic                  dec_b;
  logic                  load_ok;

  // Ripple carry/borrow through the digits and validate the load value.
  // inc_c/dec_b surviving past the top digit means the count wrapped.
  always_comb begin
    inc_val = bcd_q;
    dec_val = bcd_q;
    inc_c   = 1'b1;
    dec_b   = 1'b1;
    load_ok = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (inc_c) begin
        if (bcd_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
          inc_c = 1'b0;
        end
      end
      if (dec_b) begin
        if (bcd_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = bcd_q[4*i +: 4] - 4'd1;
          dec_b = 1'b0;
        end
      end
      if (bus.load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Count state and pulse outputs; priority is reset, then load, then counting.
  // Pulses default low so each one lasts exactly one cycle per event.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      bcd_q      <= '0;
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tick_q     <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (bus.load) begin
        // A load, accepted or not, restarts the prescaler phase.
        pc_q <= '0;
        if (load_ok) begin
          bcd_q <= bus.load_val;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (bus.en) begin
        if (pc_q == PC_LAST) begin
          pc_q   <= '0;
          tick_q <= 1'b1;
          if (bus.up) begin
            bcd_q  <= inc_val;
            wrap_q <= inc_c;
          end else begin
            bcd_q  <= dec_val;
            wrap_q <= dec_b;
          end
        end else begin
          pc_q <= pc_q + PRESCALE_W'(1);
        end
      end
    end
  end

  assign bus.bcd      = bcd_q;
  assign bus.tick     = tick_q;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter: directed scenarios plus a randomized run, all
// checked against an integer-valued model of the count.
module tb_bcd_counter;

  localparam int NDIG     = 4;
  localparam int PRESCALE = 4;
  localparam int MAXV     = 9999;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // model state: count as a plain integer plus prescaler phase and pulses
  int m_val;
  int m_pc;
  bit m_tick;
  bit m_wrap;
  bit m_err;

  bcd_counter_if #(.NDIG(NDIG)) bus ();

  bcd_counter #(.NDIG(NDIG), .PRESCALE(PRESCALE), .PRESCALE_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(logic [15:0] b);
    int v;
    v = 0;
    for (int i = NDIG - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  function automatic bit bcd_ok(logic [15:0] b);
    for (int i = 0; i < NDIG; i++) if (b[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Advance the model by one clock edge from the inputs present at that edge.
  function automatic void model_edge();
    if (rst) begin
      m_val = 0; m_pc = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    end else begin
      m_tick = 0; m_wrap = 0; m_err = 0;
      if (bus.load) begin
        m_pc = 0;
        if (bcd_ok(bus.load_val)) m_val = from_bcd(bus.load_val);
        else m_err = 1;
      end else if (bus.en) begin
        if (m_pc == PRESCALE - 1) begin
          m_pc = 0;
          m_tick = 1;
          if (bus.up) begin
            m_wrap = (m_val == MAXV);
            m_val = (m_val + 1) % (MAXV + 1);
          end else begin
            m_wrap = (m_val == 0);
            m_val = (m_val == 0) ? MAXV : m_val - 1;
          end
        end else begin
          m_pc = m_pc + 1;
        end
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Clock until tick is seen; n is the number of edges taken (limit+1 if none).
  task automatic wait_tick(input int limit, output int n);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      cyc();
      if (bus.tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load = 1'b1;
    bus.load_val = v;
    cyc();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({bus.bcd, bus.tick, bus.wrap, bus.load_err} !== 19'd0) begin
        errors++;
        $display("FAIL reset_state: got bcd=%h tick=%b wrap=%b err=%b, want 0000 0 0 0",
                 bus.bcd, bus.tick, bus.wrap, bus.load_err);
      end
    end
    rst = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h0001) begin
      errors++;
      $display("FAIL first_tick: got latency=%0d bcd=%h, want 4 0001", n, bus.bcd);
    end
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h0002) begin
      errors++;
      $display("FAIL second_tick: got latency=%0d bcd=%h, want 4 0002", n, bus.bcd);
    end
  endtask

  task automatic test_carry();
    int n;
    bus.up = 1'b1;
    do_load(16'h0999);
    checks++;
    if (bus.bcd !== 16'h0999 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL load_valid: got bcd=%h tick=%b, want 0999 0", bus.bcd, bus.tick);
    end
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h1000 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL carry_ripple: got lat=%0d bcd=%h wrap=%b, want 4 1000 0", n, bus.bcd, bus.wrap);
    end
    do_load(16'h9999);
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h0000 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap: got lat=%0d bcd=%h wrap=%b, want 4 0000 1", n, bus.bcd, bus.wrap);
    end
    cyc();
    checks++;
    if (bus.wrap !== 1'b0 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL wrap_pulse: got wrap=%b tick=%b, want 0 0", bus.wrap, bus.tick);
    end
  endtask

  task automatic test_borrow();
    int n;
    bus.up = 1'b0;
    do_load(16'h1000);
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h0999 || bus.wrap !== 1'b0) begin
      errors++;
      $display("FAIL borrow_ripple: got lat=%0d bcd=%h wrap=%b, want 4 0999 0", n, bus.bcd, bus.wrap);
    end
    do_load(16'h0000);
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h9999 || bus.wrap !== 1'b1) begin
      errors++;
      $display("FAIL down_wrap: got lat=%0d bcd=%h wrap=%b, want 4 9999 1", n, bus.bcd, bus.wrap);
    end
  endtask

  task automatic test_invalid_load();
    int n;
    bus.up = 1'b1;
    do_load(16'h0042);
    cyc();
    do_load(16'h00A5);
    checks++;
    if (bus.load_err !== 1'b1 || bus.bcd !== 16'h0042 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL invalid_load: got err=%b bcd=%h tick=%b, want 1 0042 0",
               bus.load_err, bus.bcd, bus.tick);
    end
    cyc();
    checks++;
    if (bus.load_err !== 1'b0) begin
      errors++;
      $display("FAIL load_err_pulse: got err=%b, want 0", bus.load_err);
    end
    wait_tick(40, n);
    checks++;
    if (n + 1 !== 4 || bus.bcd !== 16'h0043) begin
      errors++;
      $display("FAIL invalid_restart: got lat=%0d bcd=%h, want 4 0043", n + 1, bus.bcd);
    end
  endtask

  task automatic test_load_at_step();
    int n;
    for (int i = 0; i < 3; i++) cyc();
    do_load(16'h0500);
    checks++;
    if (bus.bcd !== 16'h0500 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL load_at_step: got bcd=%h tick=%b, want 0500 0", bus.bcd, bus.tick);
    end
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h0501) begin
      errors++;
      $display("FAIL after_step_load: got lat=%0d bcd=%h, want 4 0501", n, bus.bcd);
    end
  endtask

  task automatic test_freeze_reset();
    int n;
    logic [15:0] held;
    cyc(); cyc();
    held = bus.bcd;
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if (bus.bcd !== held || bus.tick !== 1'b0) begin
        errors++;
        $display("FAIL freeze: cycle %0d got bcd=%h tick=%b, want %h 0", i, bus.bcd, bus.tick, held);
      end
    end
    bus.en = 1'b1;
    wait_tick(40, n);
    checks++;
    if (n !== 2 || bus.bcd !== to_bcd(from_bcd(held) + 1)) begin
      errors++;
      $display("FAIL resume: got lat=%0d bcd=%h, want 2 %h", n, bus.bcd, to_bcd(from_bcd(held) + 1));
    end
    cyc(); cyc();
    rst = 1'b1;
    cyc();
    checks++;
    if (bus.bcd !== 16'h0000 || bus.tick !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got bcd=%h tick=%b, want 0000 0", bus.bcd, bus.tick);
    end
    rst = 1'b0;
    wait_tick(40, n);
    checks++;
    if (n !== 4 || bus.bcd !== 16'h0001) begin
      errors++;
      $display("FAIL post_reset_tick: got lat=%0d bcd=%h, want 4 0001", n, bus.bcd);
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    int sel;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) bus.up = ~bus.up;
      bus.load = ($urandom_range(0, 19) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: v = to_bcd(MAXV);
        1: v = to_bcd(0);
        2: v = to_bcd($urandom_range(MAXV - 3, MAXV));
        3: v = to_bcd($urandom_range(0, 3));
        4: begin
          v = to_bcd($urandom_range(0, MAXV));
          v[4*$urandom_range(0, NDIG - 1) +: 4] = 4'($urandom_range(10, 15));
        end
        default: v = to_bcd($urandom_range(0, MAXV));
      endcase
      bus.load_val = v;
      cyc();
      checks++;
      if ({bus.bcd, bus.tick, bus.wrap, bus.load_err} !== {to_bcd(m_val), m_tick, m_wrap, m_err}) begin
        errors++;
        $display("FAIL random_cycle %0d: got bcd=%h t=%b w=%b e=%b, want bcd=%h t=%b w=%b e=%b",
                 c, bus.bcd, bus.tick, bus.wrap, bus.load_err, to_bcd(m_val), m_tick, m_wrap, m_err);
      end
      checks++;
      if (!bcd_ok(bus.bcd)) begin
        errors++;
        $display("FAIL digit_legal %0d: got bcd=%h, want all nibbles <= 9", c, bus.bcd);
      end
    end
    rst = 1'b0;
    bus.load = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_val = 0; m_pc = 0; m_tick = 0; m_wrap = 0; m_err = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    test_reset();
    test_carry();
    test_borrow();
    test_invalid_load();
    test_load_at_step();
    test_freeze_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
